// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one synchronous-read unified memory between the instruction-fetch
// and load/store ports. Data normally wins; a bounded run of data grants forces a fetch.
module imem_dmem_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_resp_valid,
  output logic [31:0]           if_resp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_we,
  input  logic [31:0]           d_wdata,
  output logic                  d_resp_valid,
  output logic [31:0]           d_resp_data,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  owner_t     owner_reg, owner_next;
  logic [3:0] consec_reg, consec_next;
  logic       force_if;
  logic       grant_if;
  logic       grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_reg  <= OWN_NONE;
      consec_reg <= 4'd0;
    end else begin
      owner_reg  <= owner_next;
      consec_reg <= consec_next;
    end
  end

  // rst gates the grants so nothing is accepted while reset is held.
  always_comb begin
    force_if = if_req_valid && (consec_reg == MAX_C);
    grant_if = rst && if_req_valid && (force_if || !d_req_valid);
    grant_d  = rst && d_req_valid && !force_if;
  end

  always_comb begin
    consec_next = consec_reg;
    owner_next  = OWN_NONE;
    if (!if_req_valid || grant_if) begin
      consec_next = 4'd0;
    end else if (grant_d) begin
      consec_next = consec_reg + 4'd1;
    end
    if (grant_if) begin
      owner_next = OWN_IF;
    end else if (grant_d && (d_we == 4'b0000)) begin
      owner_next = OWN_D;
    end
  end

  always_comb begin
    if_req_ready = grant_if;
    d_req_ready  = grant_d;
    mem_en       = grant_if || grant_d;
    mem_addr     = grant_d ? d_addr : if_addr;
    mem_we       = grant_d ? d_we : 4'b0000;
    mem_wdata    = d_wdata;
  end

  // A response still owed when reset arrives is suppressed rather than delivered.
  always_comb begin
    if_resp_valid = rst && (owner_reg == OWN_IF);
    d_resp_valid  = rst && (owner_reg == OWN_D);
    if_resp_data  = mem_rdata;
    d_resp_data   = mem_rdata;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read unified memory (1-cycle read latency, byte write enables) between the Riscv151 instruction-fetch port and data (load/store) port.
- Sits between the CPU datapath and the memory macro.
- Arbitrates per cycle, routes read data back to the requester that issued the read, and bounds fetch starvation under back-to-back data traffic.

Parameters:
ADDR_WIDTH, 14, word-address width of memory and both request ports
MAX_CONSEC, 4, max consecutive data grants while fetch is waiting before fetch is forced a grant (1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge)
if_req_valid  input  1  fetch request present
if_req_ready  output  1  fetch request accepted this cycle
if_addr  input  ADDR_WIDTH  fetch word address
if_resp_valid  output  1  fetch read data valid
if_resp_data  output  32  fetch read data
d_req_valid  input  1  data request present
d_req_ready  output  1  data request accepted this cycle
d_addr  input  ADDR_WIDTH  data word address
d_we  input  4  byte write enables; 0000 = read
d_wdata  input  32  store data
d_resp_valid  output  1  load data valid (reads only)
d_resp_data  output  32  load data
mem_en  output  1  memory access enable
mem_we  output  4  memory byte write enables
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, valid the cycle after a read with mem_en=1

Behaviour:
- Grant logic is combinational from current inputs and registered state. At most one grant per cycle. Accept occurs when valid && ready in the same cycle.
- Priority, default: data over fetch.
- Starvation guard: 4-bit counter consec.
  - Increments on each data grant made while if_req_valid=1.
  - Clears on any fetch grant, or on any cycle with if_req_valid=0.
  - When consec == MAX_CONSEC and if_req_valid=1, fetch is granted and data waits.
- Ready signals:
  - if_req_ready = fetch granted.
  - d_req_ready = data granted.
  - Neither ready depends on its own valid except through the grant decision.
- Memory drive in the grant cycle:
  - mem_en=1.
  - mem_addr = granted address.
  - mem_we = d_we if data granted, else 0000.
  - mem_wdata = d_wdata.
  - With no grant: mem_en=0, mem_we=0000.
- Response pipeline:
  - Register resp_owner {NONE, IF, D} is captured at the grant.
  - Data writes (d_we != 0) capture NONE.
  - In the next cycle: owner IF -> if_resp_valid=1; owner D -> d_resp_valid=1. Each is high for exactly 1 cycle.
  - if_resp_data and d_resp_data both equal mem_rdata combinationally. Their values are don't-care when the matching valid is low.
- Throughput: one access per cycle. Back-to-back grants overlap with the previous response.
- Requesters must hold valid/addr/we/wdata stable until ready. The arbiter does not buffer requests.
- Reset (rst=0 at a clock edge):
  - resp_owner=NONE, consec=0.
  - Outputs during and after reset until the next grant: if_resp_valid=0, d_resp_valid=0, ready outputs 0, mem_en=0, mem_we=0000.
  - A response pending when reset is asserted is dropped; no resp_valid pulses after the reset edge.
- No grants while rst=0.
- Simultaneous request with consec < MAX_CONSEC -> data wins, consec++. Fetch idle -> consec held at 0.
- Write immediately followed by a read of the same address returns the new data (memory-native behaviour; no forwarding in the arbiter).

Test Plan:
- Reset held 5 cycles with both valids=1 -> no ready, no mem_en, no resp_valid. Release -> data granted first cycle, consec=1.
- Fetch-only reads of addrs 0,1,2 back-to-back (mem preloaded 0x00000013, 0x00100093, 0x12C00113) -> if_req_ready 3 consecutive cycles; if_resp_valid on the following 3 cycles with data in order; d_resp_valid stays 0.
- Both valid continuously, MAX_CONSEC=4 -> grant pattern D,D,D,D,IF,D,D,D,D,IF. Each response goes to the correct port 1 cycle later.
- Store d_we=1111, addr 0x20, wdata 300 (0x12C) -> mem_we=1111 in grant cycle, no d_resp_valid. Next load from 0x20 -> d_resp_valid with 300.
- Byte store d_we=0010, wdata 0x0000AB00 to a word holding 0x11223344 -> subsequent load returns 0x1122AB44.
- Data read granted, then rst=0 on the next edge -> no d_resp_valid after reset. After release, a fetch of addr 0 returns 0x00000013 with correct routing.
